// File: rtl/imem_arbiter.sv
// Arbitrates the single-port synchronous instruction memory between fetch and loader.
// Optional fetch anti-starvation counter enabled by defining IMEM_ARB_FAIRNESS_EN.
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_hold,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              hold_active,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t            state, state_next;
  logic              any_gnt;
  logic [ADDR_W-1:0] gnt_addr;
  logic              addr_ok;
  logic              fetch_prio;
  logic              resp_f, resp_l, resp_err, resp_we;

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  assign fetch_prio = (wait_cnt == CNT_W'(MAX_WAIT));

  // Count consecutive ARB cycles in which a pending fetch lost to the loader
  always_comb begin
    wait_cnt_next = '0;
    if (state == ARB && f_req && !f_gnt && l_gnt)
      wait_cnt_next = fetch_prio ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt <= '0;
    else     wait_cnt <= wait_cnt_next;
  end
`else
  assign fetch_prio = 1'b0;
`endif

  always_comb begin
    state_next = state;
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    case (state)
      ARB: begin
        if (l_hold) state_next = HOLD;
        if (fetch_prio && f_req) begin
          f_gnt = 1'b1;
        end else begin
          l_gnt = l_req;
          f_gnt = f_req & ~l_req;
        end
      end
      HOLD: begin
        if (!l_hold) state_next = ARB;
        l_gnt = l_req;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ARB;
    else     state <= state_next;
  end

  // Misaligned or out-of-range grants never reach the memory
  assign any_gnt  = f_gnt | l_gnt;
  assign gnt_addr = l_gnt ? l_addr : f_addr;
  assign addr_ok  = (gnt_addr[1:0] == 2'b00) && (gnt_addr[ADDR_W-1:MEM_AW+2] == '0);

  assign mem_en    = any_gnt & addr_ok;
  assign mem_we    = mem_en & l_gnt & l_we;
  assign mem_addr  = mem_en ? gnt_addr[MEM_AW+1:2] : '0;
  assign mem_wdata = (mem_en && l_gnt) ? l_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_f   <= 1'b0;
      resp_l   <= 1'b0;
      resp_err <= 1'b0;
      resp_we  <= 1'b0;
    end else begin
      resp_f   <= f_gnt;
      resp_l   <= l_gnt;
      resp_err <= any_gnt & ~addr_ok;
      resp_we  <= l_gnt & l_we;
    end
  end

  // Responses steer the memory's one-cycle-late read data to the registered owner
  assign f_rvalid    = resp_f;
  assign f_err       = resp_f & resp_err;
  assign f_rdata     = (resp_f && !resp_err) ? mem_rdata : '0;
  assign l_rvalid    = resp_l;
  assign l_err       = resp_l & resp_err;
  assign l_rdata     = (resp_l && !resp_err && !resp_we) ? mem_rdata : '0;
  assign hold_active = (state == HOLD);

endmodule

// File: tb/tb_imem_arbiter.sv
// Table-driven bench for imem_arbiter with a behavioural synchronous-read memory.
// Contention rows adapt when IMEM_ARB_FAIRNESS_EN is defined.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_gnt, f_rvalid, f_err;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_hold, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        hold_active, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_hold(l_hold),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .hold_active(hold_active), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory preloaded with word i = 0xA0000000 + i
  logic [31:0] mem [1024];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        lr;
    logic        lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        lh;
    logic [8:0]  ctrl;  // {f_gnt,l_gnt,mem_en,mem_we,hold,f_rvalid,f_err,l_rvalid,l_err}
    logic [9:0]  maddr;
    logic [31:0] frd;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic fr, logic [31:0] fa, logic lr, logic lwe,
                              logic [31:0] la, logic [31:0] lwd, logic lh,
                              logic [8:0] ctrl, logic [9:0] maddr,
                              logic [31:0] frd, logic [31:0] lrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.lr = lr; v.lwe = lwe; v.la = la; v.lwd = lwd; v.lh = lh;
    v.ctrl = ctrl; v.maddr = maddr; v.frd = frd; v.lrd = lrd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    f_req = v.fr; f_addr = v.fa;
    l_req = v.lr; l_we = v.lwe; l_addr = v.la; l_wdata = v.lwd; l_hold = v.lh;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_now();
    return {f_gnt, l_gnt, mem_en, mem_we, hold_active, f_rvalid, f_err, l_rvalid, l_err};
  endfunction

  task automatic idle();
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_hold = 0;
  endtask

  initial begin
    // Idle / fetch / loader write then fetch readback
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b0_0_0_0_0_0_0_0_0, 10'h0,   32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h8,    0, 0, 32'h0,   32'h0, 0, 9'b1_0_1_0_0_0_0_0_0, 10'h2,   32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b0_0_0_0_0_1_0_0_0, 10'h0,   32'hA000_0002, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 1, 32'h10,  32'hDEAD_BEEF, 0, 9'b0_1_1_1_0_0_0_0_0, 10'h4, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h10,   0, 0, 32'h0,   32'h0, 0, 9'b1_0_1_0_0_0_0_1_0, 10'h4,   32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b0_0_0_0_0_1_0_0_0, 10'h0,   32'hDEAD_BEEF, 32'h0));
    // Error responses, last valid word
    vecs.push_back(mk(1, 32'h6,    0, 0, 32'h0,   32'h0, 0, 9'b1_0_0_0_0_0_0_0_0, 10'h0,   32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h1000, 0, 0, 32'h0,   32'h0, 0, 9'b1_0_0_0_0_1_1_0_0, 10'h0,   32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    1, 0, 32'hFFC, 32'h0, 0, 9'b0_1_1_0_0_1_1_0_0, 10'h3FF, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b0_0_0_0_0_0_0_1_0, 10'h0,   32'h0, 32'hA000_03FF));
    // Single contention then back-to-back grants
    vecs.push_back(mk(1, 32'h0,    1, 0, 32'h4,   32'h0, 0, 9'b0_1_1_0_0_0_0_0_0, 10'h1,   32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b1_0_1_0_0_0_0_1_0, 10'h0,   32'h0, 32'hA000_0001));
    vecs.push_back(mk(0, 32'h0,    0, 0, 32'h0,   32'h0, 0, 9'b0_0_0_0_0_1_0_0_0, 10'h0,   32'hA000_0000, 32'h0));
    // Six cycles of contention
    vecs.push_back(mk(1, 32'h0, 1, 0, 32'h8, 32'h0, 0, 9'b0_1_1_0_0_0_0_0_0, 10'h2, 32'h0, 32'h0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h0, 1, 0, 32'h8, 32'h0, 0, 9'b0_1_1_0_0_0_0_1_0, 10'h2, 32'h0, 32'hA000_0002));
`ifdef IMEM_ARB_FAIRNESS_EN
    vecs.push_back(mk(1, 32'h0, 1, 0, 32'h8, 32'h0, 0, 9'b1_0_1_0_0_0_0_1_0, 10'h0, 32'h0, 32'hA000_0002));
    vecs.push_back(mk(1, 32'h0, 1, 0, 32'h8, 32'h0, 0, 9'b0_1_1_0_0_1_0_0_0, 10'h2, 32'hA000_0000, 32'h0));
`else
    for (int i = 0; i < 2; i++)
      vecs.push_back(mk(1, 32'h0, 1, 0, 32'h8, 32'h0, 0, 9'b0_1_1_0_0_0_0_1_0, 10'h2, 32'h0, 32'hA000_0002));
`endif
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 9'b0_0_0_0_0_0_0_1_0, 10'h0, 32'h0, 32'hA000_0002));
    // Hold entry, loader write in hold, exit, readback
    vecs.push_back(mk(1, 32'h0,  0, 0, 32'h0,  32'h0, 1, 9'b1_0_1_0_0_0_0_0_0, 10'h0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h0,  0, 0, 32'h0,  32'h0, 1, 9'b0_0_0_0_1_1_0_0_0, 10'h0, 32'hA000_0000, 32'h0));
    vecs.push_back(mk(1, 32'h0,  1, 1, 32'h20, 32'h1234_5678, 1, 9'b0_1_1_1_1_0_0_0_0, 10'h8, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h0,  0, 0, 32'h0,  32'h0, 0, 9'b0_0_0_0_1_0_0_1_0, 10'h0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h20, 0, 0, 32'h0,  32'h0, 0, 9'b1_0_1_0_0_0_0_0_0, 10'h8, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 9'b0_0_0_0_0_1_0_0_0, 10'h0, 32'h1234_5678, 32'h0));
    // Misaligned loader write is an error, no memory access
    vecs.push_back(mk(0, 32'h0,  1, 1, 32'h2,  32'hFFFF_FFFF, 0, 9'b0_1_0_0_0_0_0_0_0, 10'h0, 32'h0, 32'h0));
    vecs.push_back(mk(0, 32'h0,  0, 0, 32'h0,  32'h0, 0, 9'b0_0_0_0_0_0_0_1_1, 10'h0, 32'h0, 32'h0));

    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst = 1'b0;
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d ctrl", i),   32'(ctrl_now()), 32'(vecs[i].ctrl));
      checkOutput($sformatf("row%0d maddr", i),  32'(mem_addr),   32'(vecs[i].maddr));
      checkOutput($sformatf("row%0d f_rdata", i), f_rdata,        vecs[i].frd);
      checkOutput($sformatf("row%0d l_rdata", i), l_rdata,        vecs[i].lrd);
    end

    // Reset arriving while a fetch response is pending drops it
    @(negedge clk);
    idle();
    f_req = 1; f_addr = 32'h8; rst = 1'b1;
    #1;
    checkOutput("rstmid grant", 32'(f_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    checkOutput("rstmid ctrl",    32'(ctrl_now()), 32'd0);
    checkOutput("rstmid f_rdata", f_rdata,         32'd0);
    checkOutput("rstmid l_rdata", l_rdata,         32'd0);

    // Reset while in HOLD returns to ARB
    l_hold = 1;
    @(negedge clk);
    #1;
    checkOutput("rsthold entered", 32'(hold_active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    l_hold = 0;
    #1;
    checkOutput("rsthold cleared", 32'(hold_active), 32'd0);
    f_req = 1; f_addr = 32'h0;
    #1;
    checkOutput("rsthold fetch gnt", 32'(f_gnt), 32'd1);

    @(negedge clk);
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
